// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI flash arbiter.
// QSPI_XIP_CONT_EN selects continuous-read mode in the top level.
package qspi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        MODE,
        DUMMY,
        DATA,
        DONE
    } state_t;

    localparam logic [7:0] QSPI_CMD_QREAD = 8'hEB;
    localparam logic [7:0] MODE_NORM     = 8'hF0;
    localparam logic [7:0] MODE_CONT     = 8'hA0;

    localparam logic [7:0] CMD_CYC  = 8'd8;
    localparam logic [7:0] ADDR_CYC = 8'd6;
    localparam logic [7:0] MODE_CYC = 8'd2;
    localparam logic [7:0] DATA_CYC = 8'd8;

    function automatic state_t next_phase(input state_t s);
        state_t n;
        unique case (s)
            CMD:     n = ADDR;
            ADDR:    n = MODE;
            MODE:    n = DUMMY;
            DUMMY:   n = DATA;
            DATA:    n = DONE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/qspi_sck_gen.sv
// SPI mode-0 clock generator: CLK_DIV clk cycles per half-period,
// with one-cycle strobes on the clk edge where sck rises or falls.
module qspi_sck_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] ph_q, ph_d;
    logic          sck_q, sck_d;
    logic          last;

    assign last   = (ph_q == PW'(CLK_DIV - 1));
    assign rise_o = en_i & last & ~sck_q;
    assign fall_o = en_i & last & sck_q;
    assign sck_o  = sck_q;

    always_comb begin
        ph_d  = ph_q;
        sck_d = sck_q;
        if (!en_i) begin
            ph_d  = '0;
            sck_d = 1'b0;
        end else if (last) begin
            ph_d  = '0;
            sck_d = ~sck_q;
        end else begin
            ph_d = ph_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ph_q  <= '0;
            sck_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/qspi_flash_arb.sv
// Two-port round-robin arbiter issuing 0xEB quad-I/O reads to one flash.
// Define QSPI_XIP_CONT_EN to keep the flash in continuous-read mode.
module qspi_flash_arb
    import qspi_pkg::*;
#(
    parameter int CLK_DIV   = 1,
    parameter int DUMMY_CYC = 4,
    parameter int CSH_CYC   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [23:0] req0_addr,
    output logic        req0_ready,
    output logic [31:0] req0_rdata,
    input  logic        req1_valid,
    input  logic [23:0] req1_addr,
    output logic        req1_ready,
    output logic [31:0] req1_rdata,
    output logic        qspi_sck,
    output logic        qspi_cs_n,
    output logic [3:0]  qspi_dq_o,
    output logic [3:0]  qspi_dq_oe,
    input  logic [3:0]  qspi_dq_i
);

`ifdef QSPI_XIP_CONT_EN
    localparam logic [7:0] MODE_BYTE = MODE_CONT;
    localparam logic       CONT_EN   = 1'b1;
`else
    localparam logic [7:0] MODE_BYTE = MODE_NORM;
    localparam logic       CONT_EN   = 1'b0;
`endif
    localparam int CSH = (CSH_CYC < 1) ? 1 : CSH_CYC;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, len;
    logic        grant_q, grant_d, rr_q, rr_d, cont_q, cont_d;
    logic        ready0_q, ready0_d, ready1_q, ready1_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        sck_en, sck_rise, sck_fall, g;
    logic [4:0]  aidx, didx;

    assign sck_en = (state_q != IDLE) && (state_q != DONE);
    assign g      = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign aidx   = 5'd20 - {cnt_q[2:0], 2'b00};
    assign didx   = {cnt_q[2:1], ~cnt_q[0], 2'b00};

    qspi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck (
        .clk_i  (clk),
        .reset_i(reset),
        .en_i   (sck_en),
        .sck_o  (qspi_sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_comb begin
        unique case (state_q)
            CMD:     len = CMD_CYC;
            ADDR:    len = ADDR_CYC;
            MODE:    len = MODE_CYC;
            DUMMY:   len = 8'(DUMMY_CYC);
            DATA:    len = DATA_CYC;
            default: len = 8'(CSH);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        cont_d   = cont_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_d = g;
                    addr_d  = {(g ? req1_addr[23:2] : req0_addr[23:2]), 2'b00};
                    // Pointer only moves on contended grants.
                    if (req0_valid && req1_valid) rr_d = ~g;
                    state_d = cont_q ? ADDR : CMD;
                    cnt_d   = '0;
                end
            end
            CMD, ADDR, MODE, DUMMY, DATA: begin
                if (sck_rise && state_q == DATA) data_d[didx +: 4] = qspi_dq_i;
                if (sck_fall) begin
                    if (cnt_q == len - 8'd1) begin
                        cnt_d   = '0;
                        state_d = next_phase(state_q);
                        if (state_q == DATA) begin
                            ready0_d = ~grant_q;
                            ready1_d = grant_q;
                            if (grant_q) rdata1_d = data_q;
                            else         rdata0_d = data_q;
                            cont_d = CONT_EN;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                if (cnt_q >= len - 8'd1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_comb begin
        qspi_dq_o  = 4'h0;
        qspi_dq_oe = 4'h0;
        unique case (state_q)
            CMD: begin
                qspi_dq_o  = {3'b000, QSPI_CMD_QREAD[3'd7 - cnt_q[2:0]]};
                qspi_dq_oe = 4'b0001;
            end
            ADDR: begin
                qspi_dq_o  = addr_q[aidx +: 4];
                qspi_dq_oe = 4'b1111;
            end
            MODE: begin
                qspi_dq_o  = cnt_q[0] ? MODE_BYTE[3:0] : MODE_BYTE[7:4];
                qspi_dq_oe = 4'b1111;
            end
            default: ;
        endcase
    end

    assign qspi_cs_n  = (state_q == IDLE) || (state_q == DONE);
    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= 1'b0;
            rr_q     <= 1'b0;
            cont_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            cont_q   <= cont_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ready0_q <= ready0_d;
            ready1_q <= ready1_d;
        end
    end

endmodule

// File: tb/tb_qspi_flash_arb.sv
// Directed bench for qspi_flash_arb with a byte-addressed quad-read flash model.
// Instance 0 runs CLK_DIV=1, instance 1 runs CLK_DIV=2; one model serves both.
module tb_qspi_flash_arb;

    localparam int DUMMY = 4;

    typedef struct {
        int          inst;
        bit          v0;
        bit          v1;
        logic [23:0] a0;
        logic [23:0] a1;
        int          first;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    logic        clk = 1'b0;
    logic [1:0]  rst;
    logic [1:0]  rv0, rv1, rdy0, rdy1, sck, csn;
    logic [23:0] ra0 [2];
    logic [23:0] ra1 [2];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [3:0]  dqo [2];
    logic [3:0]  dqoe [2];
    logic [3:0]  fdq;
    logic        sel;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    qspi_flash_arb #(.CLK_DIV(1), .DUMMY_CYC(DUMMY), .CSH_CYC(2)) dut (
        .clk(clk), .reset(rst[0]),
        .req0_valid(rv0[0]), .req0_addr(ra0[0]),
        .req0_ready(rdy0[0]), .req0_rdata(rd0[0]),
        .req1_valid(rv1[0]), .req1_addr(ra1[0]),
        .req1_ready(rdy1[0]), .req1_rdata(rd1[0]),
        .qspi_sck(sck[0]), .qspi_cs_n(csn[0]),
        .qspi_dq_o(dqo[0]), .qspi_dq_oe(dqoe[0]), .qspi_dq_i(fdq)
    );

    qspi_flash_arb #(.CLK_DIV(2), .DUMMY_CYC(DUMMY), .CSH_CYC(2)) dut2 (
        .clk(clk), .reset(rst[1]),
        .req0_valid(rv0[1]), .req0_addr(ra0[1]),
        .req0_ready(rdy0[1]), .req0_rdata(rd0[1]),
        .req1_valid(rv1[1]), .req1_addr(ra1[1]),
        .req1_ready(rdy1[1]), .req1_rdata(rd1[1]),
        .qspi_sck(sck[1]), .qspi_cs_n(csn[1]),
        .qspi_dq_o(dqo[1]), .qspi_dq_oe(dqoe[1]), .qspi_dq_i(fdq)
    );

    // ---------------- flash model ----------------
    logic [7:0] fmem [int];
    logic       m_sck, m_cs_n;
    logic [3:0] m_dq, m_oe;
    assign m_sck  = sel ? sck[1] : sck[0];
    assign m_cs_n = sel ? csn[1] : csn[0];
    assign m_dq   = sel ? dqo[1] : dqo[0];
    assign m_oe   = sel ? dqoe[1] : dqoe[0];

    int          ncyc, cs_cnt, cs_len, clk_cnt, rise_clk, per, perr;
    bit          mstart, data_done, cap_hascmd;
    bit          mcont [2];
    logic [7:0]  cap_cmd, cap_mode;
    logic [23:0] cap_addr;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        if (fmem.exists(int'(a))) return fmem[int'(a)];
        return 8'h00;
    endfunction

    task automatic put_word(input logic [23:0] a, input logic [31:0] w);
        fmem[int'(a)]     = w[7:0];
        fmem[int'(a) + 1] = w[15:8];
        fmem[int'(a) + 2] = w[23:16];
        fmem[int'(a) + 3] = w[31:24];
    endtask

    always @(posedge clk) begin
        clk_cnt++;
        if (m_cs_n === 1'b0) cs_cnt++;
    end

    always @(negedge m_cs_n) begin
        ncyc       = 0;
        cs_cnt     = 0;
        mstart     = mcont[sel];
        cap_cmd    = 8'h00;
        cap_mode   = 8'h00;
        cap_addr   = 24'h0;
        cap_hascmd = 1'b0;
        data_done  = 1'b0;
        perr       = 0;
    end

    always @(posedge m_cs_n) begin
        cs_len = cs_cnt;
        if (data_done) mcont[sel] = (cap_mode[5:4] == 2'b10);
    end

    always @(posedge m_sck) begin : m_rise
        int rel;
        if (m_cs_n === 1'b0) begin
            per      = clk_cnt - rise_clk;
            rise_clk = clk_cnt;
            rel      = mstart ? ncyc : ncyc - 8;
            if (rel < 0) begin
                cap_cmd    = {cap_cmd[6:0], m_dq[0]};
                cap_hascmd = 1'b1;
                if (m_oe !== 4'b0001) perr++;
            end else if (rel < 6) begin
                cap_addr = {cap_addr[19:0], m_dq};
                if (m_oe !== 4'b1111) perr++;
            end else if (rel < 8) begin
                cap_mode = {cap_mode[3:0], m_dq};
                if (m_oe !== 4'b1111) perr++;
            end else begin
                if (m_oe !== 4'b0000) perr++;
                if (rel == 8 + DUMMY + 7) data_done = 1'b1;
            end
            ncyc++;
        end
    end

    always @(negedge m_sck) begin : m_fall
        int rel, j;
        logic [7:0] b;
        if (m_cs_n === 1'b0) begin
            rel = mstart ? ncyc : ncyc - 8;
            if (rel >= 8 + DUMMY && rel < 16 + DUMMY) begin
                j   = rel - 8 - DUMMY;
                b   = fbyte(cap_addr + 24'(j / 2));
                fdq = (j % 2 == 0) ? b[7:4] : b[3:0];
            end
        end
    end

    // ---------------- checking ----------------
    bit firstc [2];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rdy(input int i, output int p, output bit ok);
        ok = 1'b0;
        p  = -1;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (rdy0[i] || rdy1[i]) begin
                ok = 1'b1;
                p  = rdy0[i] ? 0 : 1;
            end
        end
    endtask

    task automatic run_rec(input vec_t r);
        int          n, port, got, div, i;
        bit          ok, hc;
        logic [31:0] exp, act;
        logic [23:0] ea;
        i   = r.inst;
        div = (i == 0) ? 1 : 2;
        @(negedge clk);
        sel    = (i == 1);
        rv0[i] = r.v0;
        ra0[i] = r.a0;
        rv1[i] = r.v1;
        ra1[i] = r.a1;
        n = (r.v0 && r.v1) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            port = (k == 0) ? r.first : 1 - r.first;
            wait_rdy(i, got, ok);
            chk("ready_timeout", 32'(ok), 32'd1);
            if (!ok) begin
                rv0[i] = 1'b0;
                rv1[i] = 1'b0;
                return;
            end
`ifdef QSPI_XIP_CONT_EN
            hc = firstc[i];
`else
            hc = 1'b1;
`endif
            exp = (port == 1) ? r.d1 : r.d0;
            ea  = ((port == 1) ? r.a1 : r.a0) & 24'hFFFFFC;
            act = (port == 1) ? rd1[i] : rd0[i];
            chk("grant_port", 32'(got), 32'(port));
            chk("rdata", act, exp);
            chk("other_ready", 32'((port == 1) ? rdy0[i] : rdy1[i]), 32'd0);
            if (port == 1) rv1[i] = 1'b0;
            else           rv0[i] = 1'b0;
            chk("wire_cmd", {23'd0, cap_hascmd, cap_cmd},
                {23'd0, hc, (hc ? 8'hEB : 8'h00)});
            chk("wire_addr", 32'(cap_addr), 32'(ea));
`ifdef QSPI_XIP_CONT_EN
            chk("wire_mode", 32'(cap_mode), 32'hA0);
`else
            chk("wire_mode", 32'(cap_mode), 32'hF0);
`endif
            chk("oe_protocol", 32'(perr), 32'd0);
            chk("cs_low_clks", 32'(cs_len), 32'((hc ? 56 : 40) * div));
            chk("sck_period", 32'(per), 32'(2 * div));
            firstc[i] = 1'b0;
            @(negedge clk);
            chk("ready_width", 32'((port == 1) ? rdy1[i] : rdy0[i]), 32'd0);
        end
    endtask

    vec_t tbl [5];

    initial begin : main
        int  thr, spur;
        bit  ok;
        vec_t r;
        rst = 2'b11;
        rv0 = 2'b00;
        rv1 = 2'b00;
        ra0[0] = '0; ra0[1] = '0; ra1[0] = '0; ra1[1] = '0;
        fdq = 4'h0;
        sel = 1'b0;
        mcont[0] = 1'b0; mcont[1] = 1'b0;
        firstc[0] = 1'b1; firstc[1] = 1'b1;
        put_word(24'h000100, 32'hDEADBEEF);
        put_word(24'h000200, 32'h12345678);
        put_word(24'h000300, 32'hCAFEF00D);
        put_word(24'hABCDEC, 32'h0F1E2D3C);
        put_word(24'hFFFFFC, 32'hA5A55A5A);

        tbl[0] = '{0, 1'b1, 1'b0, 24'h000100, 24'h000000, 0,
                   32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 1'b1, 1'b1, 24'h000300, 24'h000200, 0,
                   32'hCAFEF00D, 32'h12345678};
        tbl[2] = '{0, 1'b1, 1'b1, 24'h000100, 24'h000300, 1,
                   32'hDEADBEEF, 32'hCAFEF00D};
        tbl[3] = '{0, 1'b0, 1'b1, 24'h000000, 24'h000203, 1,
                   32'h0, 32'h12345678};
        tbl[4] = '{0, 1'b1, 1'b1, 24'hABCDEE, 24'hFFFFFF, 0,
                   32'h0F1E2D3C, 32'hA5A55A5A};

        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(csn[0]), 32'd1);
        chk("rst_sck", 32'(sck[0]), 32'd0);
        chk("rst_oe", 32'(dqoe[0]), 32'd0);
        chk("rst_dq_o", 32'(dqo[0]), 32'd0);
        chk("rst_ready", {30'd0, rdy1[0], rdy0[0]}, 32'd0);
        chk("rst_rdata0", rd0[0], 32'd0);
        chk("rst_rdata1", rd1[0], 32'd0);
        chk("rst_cs_n_div2", 32'(csn[1]), 32'd1);
        rst = 2'b00;

        for (int t = 0; t < 5; t++) run_rec(tbl[t]);
        chk("rdata0_hold", rd0[0], 32'h0F1E2D3C);

        // Reset in the middle of the DATA phase.
        @(negedge clk);
        sel    = 1'b0;
        thr    = (firstc[0] ? 8 : 0) + 6 + 2 + DUMMY + 3;
        rv0[0] = 1'b1;
        ra0[0] = 24'h000100;
        ok     = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (m_cs_n === 1'b0 && ncyc >= thr) ok = 1'b1;
        end
        chk("reach_data", 32'(ok), 32'd1);
        rst[0]   = 1'b1;
        rv0[0]   = 1'b0;
        mcont[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_cs_n", 32'(csn[0]), 32'd1);
        chk("midrst_oe", 32'(dqoe[0]), 32'd0);
        chk("midrst_sck", 32'(sck[0]), 32'd0);
        chk("midrst_ready", 32'(rdy0[0]), 32'd0);
        @(negedge clk);
        rst[0]    = 1'b0;
        firstc[0] = 1'b1;
        spur      = 0;
        repeat (100) begin
            @(negedge clk);
            if (rdy0[0] || rdy1[0]) spur++;
        end
        chk("midrst_no_ready", 32'(spur), 32'd0);
        chk("midrst_rdata0", rd0[0], 32'd0);

        r = '{0, 1'b1, 1'b0, 24'h000200, 24'h0, 0, 32'h12345678, 32'h0};
        run_rec(r);

        // CLK_DIV = 2 instance.
        r = '{1, 1'b1, 1'b0, 24'h000100, 24'h0, 0, 32'hDEADBEEF, 32'h0};
        run_rec(r);
        r = '{1, 1'b1, 1'b1, 24'h000200, 24'h000101, 0,
              32'h12345678, 32'hDEADBEEF};
        run_rec(r);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/qspi_flash_arb.md
Name: qspi_flash_arb

Overview:
- Sequences Quad-I/O fast-read transactions (0xEB) to the external W25Q16JV-class flash on qspi_cs0.
- Shares the flash between two read-only requesters: port 0 is CPU instruction/XIP fetch, port 1 is the loader/DMA path.
- Sits between the SoC memory interconnect and the QSPI pads. Each request returns one 32-bit word.

Parameters:
- CLK_DIV, 1: clk cycles per SCK half-period (>=1); SCK period = 2*CLK_DIV clk cycles.
- DUMMY_CYC, 4: SCK cycles of dummy after the mode byte.
- CSH_CYC, 2: minimum clk cycles cs_n stays high between transactions.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  port 0 request; held until req0_ready
- req0_addr  in  24  port 0 byte address; bits [1:0] ignored (treated as 0)
- req0_ready  out  1  one-cycle pulse, req0_rdata valid
- req0_rdata  out  32  port 0 read data
- req1_valid / req1_addr / req1_ready / req1_rdata: same as port 0, for port 1
- qspi_sck  out  1  flash clock, SPI mode 0
- qspi_cs_n  out  1  flash chip select, active low
- qspi_dq_o  out  4  DQ[3:0] output values
- qspi_dq_oe  out  4  DQ[3:0] output enables
- qspi_dq_i  in  4  DQ[3:0] pad inputs

Behaviour:
- Reset: state IDLE, cs_n=1, sck=0, dq_oe=0, dq_o=0, both readies=0, both rdata=0, round-robin pointer favours port 0.
- Flash QE bit is set by boot software. This block never writes status registers.
- Arbitration happens only in IDLE:
  - One valid: grant that port.
  - Both valid: grant the port not served last (round-robin).
  - The grant, and the address with [1:0]=0, are latched at the start of CMD.
  - Valid changes after the grant have no effect until DONE.
- SCK timing:
  - Phase counter counts 0..CLK_DIV-1 per half-period.
  - Outputs change only while sck is low, one clk after the falling edge (or at cs_n assertion).
  - dq_i is sampled on the clk cycle in which sck rises.
- State sequence (SCK cycles):
  - CMD: 8 cycles, 0xEB MSB-first on DQ0, oe=4'b0001.
  - ADDR: 6 cycles, address nibbles MSB-first, oe=4'b1111.
  - MODE: 2 cycles, nibbles 0xF then 0x0 (mode byte 0xF0), oe=4'b1111.
  - DUMMY: DUMMY_CYC cycles, oe=0.
  - DATA: 8 cycles, oe=0. Nibbles are assembled little-endian by byte, high nibble first within each byte: rdata[7:4], [3:0], [15:12], … [31:28].
  - DONE: sck=0, cs_n=1; granted port's ready pulses for exactly 1 clk, with rdata registered the same cycle.
  - Then cs_n is held high for CSH_CYC clks before returning to IDLE.
- Transaction length at CLK_DIV=1, DUMMY_CYC=4: 28 SCK = 56 clk from cs_n low to the last rising-edge sample.
- Ready is never asserted to the non-granted port.
- rdata holds its value until the next completion on that port.
- If the granted requester drops valid mid-transaction, the transaction still completes and ready still pulses.
- Reset mid-transaction: next cycle is IDLE with all reset values; the partial word is discarded.
- Back-to-back requests are allowed: the next grant is evaluated in the first IDLE cycle after the CSH hold.

Optional Feature:
- QSPI_XIP_CONT_EN defined (continuous-read mode):
  - Mode byte is 0xA0; the flash is left in continuous-read mode.
  - The next transaction skips CMD and starts at ADDR (20 SCK cycles).
  - Reset clears the continuous flag; the first transaction after reset always sends CMD.
- Undefined: mode byte 0xF0 and CMD is sent on every transaction.

Decomposition:
- Shared package qspi_pkg:
  - State enum (IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE).
  - Constants QSPI_CMD_QREAD=8'hEB, MODE_NORM=8'hF0, MODE_CONT=8'hA0, and per-state SCK cycle counts.
- One natural sub-module, qspi_sck_gen: CLK_DIV phase counter producing sck plus rise/fall strobe pulses consumed by the FSM.

Test Plan:
- Flash preloaded with 0x00000100=0xDEADBEEF. req0 at 0x000100 -> req0_ready after one 0xEB sequence, req0_rdata=0xDEADBEEF, req1_ready stays 0.
- req0 and req1 (addr 0x000200, holding 0x12345678) asserted in the same cycle after reset -> port 0 served first, then port 1. Next simultaneous pair -> port 1 first.
- req1 at 0x000203 -> treated as 0x000200, returns 0x12345678.
- Reset asserted mid-DATA -> next cycle cs_n=1, oe=0, no ready pulse. A new req0 afterwards completes correctly.
- CLK_DIV=2 -> SCK period 4 clk, cs_n low for 112 clk, data matches.
- QSPI_XIP_CONT_EN: two consecutive req0 reads -> first sends 0xEB, second starts with address. Both return correct data; mode byte on the wire is 0xA0.
